// File: rtl/mem_responder.sv
// Memory-side responder: services cs/read_req/write_req requests from a 16-bit word array
// after LATENCY wait states and acknowledges with a four-phase mem_resp handshake.
// Optional request statistics ports are enabled with `define MEM_RESPONDER_STATS_EN.
`timescale 1ns/1ps
module mem_responder #(
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 16,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cs,
   input  logic              read_req,
   input  logic              write_req,
   input  logic [ADDR_W-1:0] addrout,
   input  logic [DATA_W-1:0] datatomem,
   output logic [DATA_W-1:0] datafrommem,
   output logic              mem_resp,
   output logic              busy
`ifdef MEM_RESPONDER_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        r_state;
   logic [4:0]        r_cnt;
   logic              r_resp;
   logic [DATA_W-1:0] r_rdata;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_op_wr;
   logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1] = '{default: '0};

   logic w_req;
   logic w_release;
   logic w_accept;
   logic w_enter_resp;

   assign w_req        = cs & (read_req | write_req);
   assign w_release    = ~w_req;
   assign w_accept     = (r_state == S_IDLE) & w_req;
   assign w_enter_resp = (r_state == S_WAIT) & (r_cnt == 5'd1);

   // Counter holds LATENCY+1 so RESP is entered LATENCY+1 edges after acceptance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_resp  <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_cnt   <= 5'(LATENCY + 1);
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 5'd1) begin
                  r_cnt   <= '0;
                  r_resp  <= 1'b1;
                  r_state <= S_RESP;
                  if (!r_op_wr) r_rdata <= r_mem[r_addr];
               end else begin
                  r_cnt <= r_cnt - 5'd1;
               end
            end
            S_RESP: begin
               if (w_release) begin
                  r_resp  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_resp  <= 1'b0;
            end
         endcase
      end
   end

   // Request capture and array write carry no reset: array contents survive reset
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr  <= addrout;
         r_wdata <= datatomem;
         r_op_wr <= write_req;
      end
      if (w_enter_resp && r_op_wr) r_mem[r_addr] <= r_wdata;
   end

`ifdef MEM_RESPONDER_STATS_EN
   logic [15:0] r_rd_count;
   logic [15:0] r_wr_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else if (w_enter_resp) begin
         if (r_op_wr) r_wr_count <= r_wr_count + 16'd1;
         else         r_rd_count <= r_rd_count + 16'd1;
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`endif

   assign datafrommem = r_rdata;
   assign mem_resp    = r_resp;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (LATENCY=2 and LATENCY=0) share one master,
// a reference array model predicts read data, response edge and mem_resp width.
`timescale 1ns/1ps
module tb_mem_responder;

   localparam int LAT_A = 2;
   localparam int LAT_B = 0;

   typedef struct {
      int          acc;
      logic [15:0] data;
      int          width;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cs = 1'b0;
   logic        read_req = 1'b0;
   logic        write_req = 1'b0;
   logic [13:0] addrout = '0;
   logic [15:0] datatomem = '0;

   logic [15:0] rdat_a, rdat_b;
   logic        resp_a, resp_b, busy_a, busy_b;
`ifdef MEM_RESPONDER_STATS_EN
   logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
   int          n_rd = 0;
   int          n_wr = 0;
`endif

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   ent_t q0[$];
   ent_t q1[$];
   logic [15:0] mdl [int];
   logic [15:0] mdl_rd = '0;

   mem_responder #(.ADDR_W(14), .DATA_W(16), .LATENCY(LAT_A)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .cs(cs), .read_req(read_req), .write_req(write_req),
      .addrout(addrout), .datatomem(datatomem), .datafrommem(rdat_a), .mem_resp(resp_a),
      .busy(busy_a)
`ifdef MEM_RESPONDER_STATS_EN
      , .rd_count(rdc_a), .wr_count(wrc_a)
`endif
   );

   mem_responder #(.ADDR_W(14), .DATA_W(16), .LATENCY(LAT_B)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .cs(cs), .read_req(read_req), .write_req(write_req),
      .addrout(addrout), .datatomem(datatomem), .datafrommem(rdat_b), .mem_resp(resp_b),
      .busy(busy_b)
`ifdef MEM_RESPONDER_STATS_EN
      , .rd_count(rdc_b), .wr_count(wrc_b)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] mdl_get(input logic [13:0] a);
      return mdl.exists(int'(a)) ? mdl[int'(a)] : 16'h0000;
   endfunction

   // Monitor: pops one expectation per rising mem_resp, measures pulse width
   logic resp_v[2];
   logic busy_v[2];
   logic [15:0] rdat_v[2];
   assign resp_v[0] = resp_a;
   assign resp_v[1] = resp_b;
   assign busy_v[0] = busy_a;
   assign busy_v[1] = busy_b;
   assign rdat_v[0] = rdat_a;
   assign rdat_v[1] = rdat_b;

   logic prev_v[2] = '{1'b0, 1'b0};
   bit   act_v[2] = '{1'b0, 1'b0};
   int   wcnt[2] = '{0, 0};
   ent_t cur[2];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (resp_v[k] && !prev_v[k]) begin
            int qs;
            qs = (k == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
               chk($sformatf("unexpected_resp[%0d]", k), 32'd1, 32'd0);
            end else begin
               if (k == 0) cur[k] = q0.pop_front();
               else        cur[k] = q1.pop_front();
               chk($sformatf("resp_edge[%0d]", k), cyc, cur[k].acc + ((k == 0) ? LAT_A : LAT_B) + 1);
               chk($sformatf("rdata[%0d]", k), {16'h0, rdat_v[k]}, {16'h0, cur[k].data});
               act_v[k] = 1'b1;
               wcnt[k]  = 1;
            end
         end else if (resp_v[k]) begin
            wcnt[k]++;
         end else if (prev_v[k] && act_v[k]) begin
            chk($sformatf("resp_width[%0d]", k), wcnt[k], cur[k].width);
            chk($sformatf("busy_fall[%0d]", k), {31'h0, busy_v[k]}, 32'd0);
            act_v[k] = 1'b0;
         end
         prev_v[k] = resp_v[k];
      end
   end

   task automatic txn(input bit w, input bit r, input logic [13:0] a, input logic [15:0] d,
                      input int hold, input bit abort);
      ent_t ea, eb;
      int   n;
      @(negedge clk);
      cs = 1'b1; write_req = w; read_req = r; addrout = a; datatomem = d;
      @(posedge clk); #1;
      ea.acc = cyc;
      if (w) begin
         ea.data = mdl_rd;
         mdl[int'(a)] = d;
`ifdef MEM_RESPONDER_STATS_EN
         n_wr++;
`endif
      end else begin
         ea.data = mdl_get(a);
         mdl_rd  = ea.data;
`ifdef MEM_RESPONDER_STATS_EN
         n_rd++;
`endif
      end
      eb = ea;
      ea.width = abort ? 1 : hold + 1;
      eb.width = abort ? 1 : hold + 1 + LAT_A - LAT_B;
      q0.push_back(ea);
      q1.push_back(eb);
      chk("busy_accept_a", {31'h0, busy_a}, 32'd1);
      chk("busy_accept_b", {31'h0, busy_b}, 32'd1);
      @(negedge clk);
      addrout   = 14'($urandom);
      datatomem = 16'($urandom);
      if (abort) begin
         @(negedge clk);
         if ($urandom_range(0, 1) == 0) cs = 1'b0;
         else begin read_req = 1'b0; write_req = 1'b0; end
      end else begin
         n = 0;
         while (!resp_a && n < 40) begin @(negedge clk); n++; end
         if (n >= 40) chk("resp_timeout", 32'd0, 32'd1);
         repeat (hold) @(negedge clk);
         if ($urandom_range(0, 1) == 0) cs = 1'b0;
         else begin read_req = 1'b0; write_req = 1'b0; end
      end
      n = 0;
      do begin @(negedge clk); n++; end
      while ((resp_a || resp_b || busy_a || busy_b) && n < 40);
      if (n >= 40) chk("release_timeout", 32'd0, 32'd1);
      cs = 1'b0; read_req = 1'b0; write_req = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_resp_a"}, {31'h0, resp_a}, 32'd0);
      chk({tag, "_busy_a"}, {31'h0, busy_a}, 32'd0);
      chk({tag, "_rdata_a"}, {16'h0, rdat_a}, 32'd0);
      chk({tag, "_resp_b"}, {31'h0, resp_b}, 32'd0);
      chk({tag, "_busy_b"}, {31'h0, busy_b}, 32'd0);
      chk({tag, "_rdata_b"}, {16'h0, rdat_b}, 32'd0);
      mdl_rd = '0;
`ifdef MEM_RESPONDER_STATS_EN
      n_rd = 0;
      n_wr = 0;
      chk({tag, "_rdcnt_a"}, {16'h0, rdc_a}, 32'd0);
      chk({tag, "_wrcnt_b"}, {16'h0, wrc_b}, 32'd0);
`endif
   endtask

   initial begin
      logic [13:0] a;
      logic [13:0] pool [6];
      int          op;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_checks("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      txn(1'b1, 1'b0, 14'h0123, 16'hBEEF, 1, 1'b0);
      txn(1'b0, 1'b1, 14'h0123, 16'h0000, 0, 1'b0);
      txn(1'b1, 1'b1, 14'h3FFF, 16'h5A5A, 1, 1'b0);
      txn(1'b0, 1'b1, 14'h3FFF, 16'h0000, 1, 1'b0);
      txn(1'b0, 1'b1, 14'h0123, 16'h0000, 4, 1'b0);
      txn(1'b1, 1'b0, 14'h0010, 16'h1234, 0, 1'b1);
      txn(1'b0, 1'b1, 14'h0010, 16'h0000, 2, 1'b0);

      // Reset while both instances are still waiting on a write
      @(negedge clk);
      cs = 1'b1; write_req = 1'b1; read_req = 1'b0; addrout = 14'h0005; datatomem = 16'hFFFF;
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      reset_checks("midop");
      @(negedge clk);
      cs = 1'b0; write_req = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      txn(1'b0, 1'b1, 14'h0005, 16'h0000, 1, 1'b0);

      pool = '{14'h0000, 14'h3FFF, 14'h0123, 14'h0010, 14'h0005, 14'h0007};
      for (int i = 0; i < 40; i++) begin
         a  = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 7)) : pool[$urandom_range(0, 5)];
         op = $urandom_range(0, 2);
         txn(op != 0, op != 1, a, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      end

      @(negedge clk);
      reset_n = 1'b0;
      #1;
      reset_checks("final_reset");
      @(negedge clk);
      reset_n = 1'b1;
      txn(1'b0, 1'b1, 14'h0123, 16'h0000, 0, 1'b0);
      txn(1'b1, 1'b0, 14'h0020, 16'hA55A, 0, 1'b0);
      txn(1'b0, 1'b1, 14'h0020, 16'h0000, 1, 1'b0);
      txn(1'b1, 1'b1, 14'h0021, 16'h0F0F, 0, 1'b0);
      txn(1'b0, 1'b1, 14'h0021, 16'h0000, 0, 1'b0);
      repeat (3) @(negedge clk);
`ifdef MEM_RESPONDER_STATS_EN
      chk("rd_count_a", {16'h0, rdc_a}, n_rd);
      chk("wr_count_a", {16'h0, wrc_a}, n_wr);
      chk("rd_count_b", {16'h0, rdc_b}, 32'd3);
      chk("wr_count_b", {16'h0, wrc_b}, 32'd2);
`endif
      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
